button_debouncer: RTL

- Conditions one raw, bouncing push-button input into a clean, synchronous level plus single-cycle press/release strobes.
- Sits directly upstream of the up/down counter top level and replaces its raw button path.
- Its press strobe restarts the counter loop; its level drives the counters' reset/enable logic.
- Runs on the 12 MHz board clock, before any clock division.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_debouncer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and 12 MHz timing defaults for the button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int CLK_HZ        = 12_000_000;
  localparam int DEBOUNCE_MS   = 50;
  localparam int LONG_PRESS_MS = 2000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; RESET_VAL sets the idle value
// both flops are forced to while reset is asserted.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops are written with <= so both stages sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: clean level plus press/release strobes.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to add the long_pulse long-press strobe.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int COUNT_WIDTH  = 20,
  parameter int STABLE_COUNT = ms_to_cycles(DEBOUNCE_MS) - 1,
  parameter bit ACTIVE_LOW   = 1'b1
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  ,
  parameter int LONG_COUNT   = ms_to_cycles(LONG_PRESS_MS) - 1,
  parameter int LONG_WIDTH   = 25
`endif
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  ,
  output logic long_pulse
`endif
);

  localparam logic [COUNT_WIDTH-1:0] STABLE_C = COUNT_WIDTH'(STABLE_COUNT);

  logic                   btn_sync;
  logic                   samp;
  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] cnt, cnt_next;
  logic                   level_next, press_next, release_next;

  // Idle pin level is 1 for an active-low button, so reset to the released value.
  sync_2ff #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_btn),
    .d    (btn_in),
    .q    (btn_sync)
  );

  assign samp = ACTIVE_LOW ? ~btn_sync : btn_sync;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    level_next   = btn_level;
    press_next   = 1'b0;
    release_next = 1'b0;
    unique case (state)
      RELEASED: if (samp) begin
        state_next = WAIT_PRESS;
        cnt_next   = '0;
      end
      WAIT_PRESS: begin
        if (!samp) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == STABLE_C) begin
          state_next = PRESSED;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + COUNT_WIDTH'(1);
        end
      end
      PRESSED: if (!samp) begin
        state_next = WAIT_RELEASE;
        cnt_next   = '0;
      end
      WAIT_RELEASE: begin
        if (samp) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == STABLE_C) begin
          state_next   = RELEASED;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state         <= RELEASED;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      btn_level     <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] LONG_C = LONG_WIDTH'(LONG_COUNT);

  logic [LONG_WIDTH-1:0] long_cnt;
  logic                  long_done;

  // Counts while held (a release bounce back to PRESSED keeps the count);
  // long_done limits the strobe to one per press.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      long_cnt   <= '0;
      long_done  <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (state == WAIT_PRESS && state_next == PRESSED) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if (state == PRESSED || state == WAIT_RELEASE) begin
        if (long_cnt == LONG_C) begin
          if (!long_done) begin
            long_pulse <= 1'b1;
            long_done  <= 1'b1;
          end
        end else begin
          long_cnt <= long_cnt + LONG_WIDTH'(1);
        end
      end else begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end
    end
  end
`endif

endmodule
